// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
package bcd_serial_add_ctrl_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_serial_add_ctrl_fadd.sv
// Single-digit BCD full adder; the only arithmetic in the serial datapath.
module bcd_fadd_1digit
  import bcd_serial_add_ctrl_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] sum_c,
  output logic               cout_c
);

  logic [DIGIT_W:0] raw;

  // Binary add, then +6 correction when the result passes 9.
  always_comb begin
    raw    = (DIGIT_W+1)'(a) + (DIGIT_W+1)'(b) + (DIGIT_W+1)'(cin);
    sum_c  = raw[DIGIT_W-1:0];
    cout_c = 1'b0;
    if (raw > (DIGIT_W+1)'(9)) begin
      sum_c  = DIGIT_W'(raw + (DIGIT_W+1)'(6));
      cout_c = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one digit per cycle through a shared adder.
module bcd_serial_add_ctrl
  import bcd_serial_add_ctrl_pkg::*;
#(
  parameter int unsigned NDIGITS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [DIGIT_W*NDIGITS-1:0] a,
  input  logic [DIGIT_W*NDIGITS-1:0] b,
  input  logic                       cin,
  output logic                       busy,
  output logic                       done,
  output logic [DIGIT_W*NDIGITS-1:0] sum,
  output logic                       cout,
  output logic                       bad_digit
);

  localparam int unsigned W     = DIGIT_W * NDIGITS;
  localparam int unsigned IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIGITS - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 carry_q, carry_d;
  logic [W-1:0]         a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic                 cout_q, cout_d, busy_q, busy_d, done_q, done_d;
  logic                 bad_q, bad_d;

  logic [DIGIT_W-1:0]   a_dig_c, b_dig_c, add_s_c;
  logic                 add_co_c, bad_in_c;

  // Select the current digit pair from the captured operands.
  always_comb begin
    a_dig_c = '0;
    b_dig_c = '0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_dig_c = a_q[i*DIGIT_W +: DIGIT_W];
        b_dig_c = b_q[i*DIGIT_W +: DIGIT_W];
      end
    end
  end

  // Flag any non-decimal digit on the incoming operands.
  always_comb begin
    bad_in_c = 1'b0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if ((a[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(9)) ||
          (b[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(9))) begin
        bad_in_c = 1'b1;
      end
    end
  end

  bcd_fadd_1digit u_fadd (
    .a      (a_dig_c),
    .b      (b_dig_c),
    .cin    (carry_q),
    .sum_c  (add_s_c),
    .cout_c (add_co_c)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    bad_d   = bad_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          bad_d   = bad_in_c;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int unsigned i = 0; i < NDIGITS; i++) begin
          if (idx_q == IDX_W'(i)) sum_d[i*DIGIT_W +: DIGIT_W] = add_s_c;
        end
        carry_d = add_co_c;
        // idx parks on the last digit rather than wrapping.
        if (idx_q == IDX_LAST) begin
          cout_d  = add_co_c;
          state_d = ST_DONE;
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          busy_d = 1'b1;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      bad_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      bad_q   <= bad_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign bad_digit = bad_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl with hand-computed expected results.
module tb_bcd_serial_add_ctrl;

  localparam int unsigned ND = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, cin;
  logic [15:0]   a, b;
  logic          busy, done, cout, bad_digit;
  logic [15:0]   sum;

  int checks = 0;
  int passed = 0;
  int lat, ndone, gap;

  bcd_serial_add_ctrl #(.NDIGITS(ND)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .bad_digit (bad_digit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Called at a negedge: pulse start for one edge, then wait (bounded) for done.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                        output int latency);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    latency = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done) begin
        latency = n;
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_bad",  32'(bad_digit), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add, latency and pulse width.
    run_op(16'h1234, 16'h5678, 1'b0, lat);
    chk("lat_1234", 32'(lat), 32'd6);
    chk("sum_1234", 32'(sum), 32'h6912);
    chk("cout_1234", 32'(cout), 32'd0);
    chk("busy_in_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("sum_held", 32'(sum), 32'h6912);

    // Ripple carry through every digit.
    run_op(16'h9999, 16'h0001, 1'b0, lat);
    chk("sum_9999p1", 32'(sum), 32'h0000);
    chk("cout_9999p1", 32'(cout), 32'd1);
    chk("bad_9999p1", 32'(bad_digit), 32'd0);

    run_op(16'h0000, 16'h0000, 1'b1, lat);
    chk("sum_cin", 32'(sum), 32'h0001);
    chk("cout_cin", 32'(cout), 32'd0);

    run_op(16'h9999, 16'h9999, 1'b1, lat);
    chk("sum_max", 32'(sum), 32'h9999);
    chk("cout_max", 32'(cout), 32'd1);

    run_op(16'h0999, 16'h0001, 1'b0, lat);
    chk("sum_0999p1", 32'(sum), 32'h1000);
    chk("cout_0999p1", 32'(cout), 32'd0);

    // Start during RUN is ignored; operand changes after capture have no effect.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("busy_run", 32'(busy), 32'd1);
    @(negedge clk);
    a = 16'h5555; b = 16'h4444; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("sum_ignored_start", 32'(sum), 32'h3333);
      end
    end
    chk("one_done_pulse", 32'(ndone), 32'd1);

    // Reset in RUN cycle 2 aborts with no done.
    a = 16'h4321; b = 16'h1111; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_sum",  32'(sum),  32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("no_done_after_abort", 32'(ndone), 32'd0);
    run_op(16'h4321, 16'h1111, 1'b0, lat);
    chk("lat_after_rst", 32'(lat), 32'd6);
    chk("sum_after_rst", 32'(sum), 32'h5432);

    // Illegal digit flagged, then cleared by a legal operation.
    run_op(16'h12A4, 16'h0001, 1'b0, lat);
    chk("bad_set", 32'(bad_digit), 32'd1);
    chk("bad_done_seen", 32'(lat), 32'd6);
    run_op(16'h0002, 16'h0003, 1'b0, lat);
    chk("bad_cleared", 32'(bad_digit), 32'd0);
    chk("sum_after_bad", 32'(sum), 32'h0005);

    // Held start: back-to-back operations every NDIGITS+2 cycles.
    @(negedge clk);
    a = 16'h0011; b = 16'h0022; cin = 1'b0; start = 1'b1;
    gap = -1;
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (done) begin
        if (lat < 0) lat = n;
        else begin
          gap = n - lat;
          break;
        end
      end
    end
    chk("held_start_gap", 32'(gap), 32'd6);
    chk("held_start_sum", 32'(sum), 32'h0033);
    start = 1'b0;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
